// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt source controller: register window
// indices, MODE bit encodings and TIMER_CTRL bit positions.
package irq_pkg;

  localparam int NUM_IRQ_DEFAULT = 16;
  localparam int BUS_AW = 4;
  localparam int BUS_DW = 32;

  typedef enum logic [3:0] {
    REG_ENABLE      = 4'd0,
    REG_MODE        = 4'd1,
    REG_PENDING     = 4'd2,
    REG_INSERVICE   = 4'd3,
    REG_EOI         = 4'd4,
    REG_OVF         = 4'd5,
    REG_SWTRIG      = 4'd6,
    REG_TIMER_LOAD  = 4'd7,
    REG_TIMER_COUNT = 4'd8,
    REG_TIMER_CTRL  = 4'd9
  } reg_idx_e;

  localparam logic MODE_EDGE  = 1'b0;
  localparam logic MODE_LEVEL = 1'b1;

  localparam int TCTRL_EN_BIT  = 0;
  localparam int TCTRL_PER_BIT = 1;

endpackage

// File: rtl/irq_source_ctrl_if.sv
// Register-window bus between a software master and the interrupt source
// controller; read data is registered by the slave.
interface irq_source_ctrl_if;
  import irq_pkg::*;

  logic              bus_we;
  logic              bus_re;
  logic [BUS_AW-1:0] bus_addr;
  logic [BUS_DW-1:0] bus_wdata;
  logic [BUS_DW-1:0] bus_rdata;

  modport master (
    output bus_we, bus_re, bus_addr, bus_wdata,
    input  bus_rdata
  );

  modport slave (
    input  bus_we, bus_re, bus_addr, bus_wdata,
    output bus_rdata
  );

endinterface

// File: rtl/irq_sync_edge.sv
// Multi-flop synchronizer for one asynchronous request line, plus a
// rising-edge detector on the synchronized value.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign sync = chain[SYNC_STAGES-1];
  assign rise = sync & ~prev;

endmodule

// File: rtl/irq_source_ctrl.sv
// Interrupt source controller: qualifies synchronized request lines into
// PENDING and delivers one-cycle pulses. Optional line-0 timer: IRQ_TIMER_EN.
module irq_source_ctrl
  import irq_pkg::*;
#(
  parameter int NUM_IRQ     = NUM_IRQ_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_en,
  input  logic [NUM_IRQ-1:0] irq_in,
  irq_source_ctrl_if.slave   bus,
  output logic [NUM_IRQ-1:0] interrupts
);

  logic [NUM_IRQ-1:0] enable, mode, pending, inservice, ovf;
  logic [NUM_IRQ-1:0] sync_s, sync_rise;
  logic [NUM_IRQ-1:0] is_level, edge_src, level_src;
  logic [NUM_IRQ-1:0] sw_ev, edge_ev, level_ev, deliver;
  logic [NUM_IRQ-1:0] wbits;
  logic               wr_enable, wr_mode, wr_eoi, wr_ovf, wr_swtrig;
  logic [BUS_DW-1:0]  rdata_mux;
  logic               unused_bits;

`ifdef IRQ_TIMER_EN
  logic [31:0] timer_load, timer_count;
  logic        timer_on, timer_per, timer_fire;
  logic        wr_tload, wr_tctrl;
`endif

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
    irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (irq_in[g]),
      .sync (sync_s[g]),
      .rise (sync_rise[g])
    );
  end

  assign wbits     = bus.bus_wdata[NUM_IRQ-1:0];
  assign wr_enable = bus.bus_we && (bus.bus_addr == REG_ENABLE);
  assign wr_mode   = bus.bus_we && (bus.bus_addr == REG_MODE);
  assign wr_eoi    = bus.bus_we && (bus.bus_addr == REG_EOI);
  assign wr_ovf    = bus.bus_we && (bus.bus_addr == REG_OVF);
  assign wr_swtrig = bus.bus_we && (bus.bus_addr == REG_SWTRIG);

  // Line 0 becomes an edge-type timer source when the timer is built in
  always_comb begin
    for (int i = 0; i < NUM_IRQ; i++) is_level[i] = (mode[i] == MODE_LEVEL);
    edge_src  = sync_rise;
    level_src = sync_s;
`ifdef IRQ_TIMER_EN
    is_level[0]  = 1'b0;
    edge_src[0]  = timer_fire;
    level_src[0] = 1'b0;
`endif
  end

  assign sw_ev    = wr_swtrig ? wbits : '0;
  assign edge_ev  = (edge_src & ~is_level) | sw_ev;
  assign level_ev = level_src & is_level & ~inservice;
  assign deliver  = clk_en ? (pending & enable & ~inservice) : '0;

  // New events override the delivery clear, so a same-cycle event re-pends
  always_ff @(posedge clk) begin
    if (rst) begin
      enable     <= '0;
      mode       <= '0;
      pending    <= '0;
      inservice  <= '0;
      ovf        <= '0;
      interrupts <= '0;
    end else begin
      if (wr_enable) enable <= wbits;
      if (wr_mode)   mode   <= wbits;
      pending    <= (pending & ~deliver) | edge_ev | level_ev;
      inservice  <= (inservice & ~(wr_eoi ? wbits : '0)) | (deliver & is_level);
      ovf        <= (ovf & ~(wr_ovf ? wbits : '0)) | (edge_ev & pending & ~deliver);
      interrupts <= deliver;
    end
  end

`ifdef IRQ_TIMER_EN
  assign wr_tload   = bus.bus_we && (bus.bus_addr == REG_TIMER_LOAD);
  assign wr_tctrl   = bus.bus_we && (bus.bus_addr == REG_TIMER_CTRL);
  assign timer_fire = timer_on && clk_en && (timer_count == '0) && !wr_tctrl;

  // A TIMER_CTRL write takes precedence over counting in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_load  <= '0;
      timer_count <= '0;
      timer_on    <= 1'b0;
      timer_per   <= 1'b0;
    end else begin
      if (wr_tload) timer_load <= bus.bus_wdata;
      if (wr_tctrl) begin
        timer_on  <= bus.bus_wdata[TCTRL_EN_BIT];
        timer_per <= bus.bus_wdata[TCTRL_PER_BIT];
        if (bus.bus_wdata[TCTRL_EN_BIT]) timer_count <= timer_load;
      end else if (timer_on && clk_en) begin
        if (timer_count == '0) begin
          if (timer_per) timer_count <= timer_load;
          else           timer_on    <= 1'b0;
        end else begin
          timer_count <= timer_count - 32'd1;
        end
      end
    end
  end
`endif

  always_comb begin
    rdata_mux = '0;
    case (bus.bus_addr)
      REG_ENABLE:      rdata_mux[NUM_IRQ-1:0] = enable;
      REG_MODE:        rdata_mux[NUM_IRQ-1:0] = mode;
      REG_PENDING:     rdata_mux[NUM_IRQ-1:0] = pending;
      REG_INSERVICE:   rdata_mux[NUM_IRQ-1:0] = inservice;
      REG_OVF:         rdata_mux[NUM_IRQ-1:0] = ovf;
`ifdef IRQ_TIMER_EN
      REG_TIMER_LOAD:  rdata_mux = timer_load;
      REG_TIMER_COUNT: rdata_mux = timer_count;
      REG_TIMER_CTRL: begin
        rdata_mux[TCTRL_EN_BIT]  = timer_on;
        rdata_mux[TCTRL_PER_BIT] = timer_per;
      end
`endif
      default:         rdata_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)             bus.bus_rdata <= '0;
    else if (bus.bus_re) bus.bus_rdata <= rdata_mux;
  end

  assign unused_bits = ^{bus.bus_wdata, sync_s, sync_rise};

endmodule

// File: tb/tb_irq_source_ctrl.sv
// Directed bench for irq_source_ctrl with an in-bench behavioural model
// checked every cycle, plus hand-computed literal expectations.
`timescale 1ns/1ps
module tb_irq_source_ctrl;
  import irq_pkg::*;

  localparam int N  = 16;
  localparam int SS = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         clk_en;
  logic [N-1:0] irq_in;
  logic [N-1:0] interrupts;

  irq_source_ctrl_if bus_if();

  irq_source_ctrl #(.NUM_IRQ(N), .SYNC_STAGES(SS)) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_en     (clk_en),
    .irq_in     (irq_in),
    .bus        (bus_if),
    .interrupts (interrupts)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  bit chk_on  = 1'b0;

  // Model state
  logic [N-1:0] m_en, m_mode, m_pend, m_insv, m_ovf, m_int;
  logic [N-1:0] hist [SS+1];   // hist[k] = irq_in sampled k+1 edges ago
  logic [31:0]  m_rdata;
  logic         m_rd_chk;
  logic [31:0]  m_tload, m_tcnt;
  logic         m_ten, m_tper;

  function automatic logic [31:0] model_read(input logic [3:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      4'd0: r[N-1:0] = m_en;
      4'd1: r[N-1:0] = m_mode;
      4'd2: r[N-1:0] = m_pend;
      4'd3: r[N-1:0] = m_insv;
      4'd5: r[N-1:0] = m_ovf;
`ifdef IRQ_TIMER_EN
      4'd7: r = m_tload;
      4'd8: r = m_tcnt;
      4'd9: r = {30'd0, m_tper, m_ten};
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin : model
    logic [N-1:0] nx_pend, nx_insv, nx_ovf, nx_int;
    logic lvl, hs, hp, e_ev, l_ev, dlv, tfire, ctrl_wr, we;
    logic [3:0] a;
    logic [31:0] d;
    we = bus_if.bus_we; a = bus_if.bus_addr; d = bus_if.bus_wdata;
    if (rst) begin
      m_en = '0; m_mode = '0; m_pend = '0; m_insv = '0; m_ovf = '0; m_int = '0;
      for (int k = 0; k <= SS; k++) hist[k] = '0;
      m_rdata = '0; m_rd_chk = 1'b0;
      m_tload = '0; m_tcnt = '0; m_ten = 1'b0; m_tper = 1'b0;
    end else begin
      m_rd_chk = bus_if.bus_re;
      if (bus_if.bus_re) m_rdata = model_read(a);
      ctrl_wr = we && (a == 4'd9);
      tfire   = 1'b0;
`ifdef IRQ_TIMER_EN
      tfire = m_ten && clk_en && (m_tcnt == 0) && !ctrl_wr;
`endif
      for (int i = 0; i < N; i++) begin
        lvl = (m_mode[i] == MODE_LEVEL);
        hs = hist[SS-1][i];
        hp = hist[SS][i];
        e_ev = 1'b0;
        l_ev = 1'b0;
`ifdef IRQ_TIMER_EN
        if (i == 0) begin lvl = 1'b0; hs = 1'b0; hp = 1'b0; e_ev = tfire; end
`endif
        if (!lvl && hs && !hp) e_ev = 1'b1;
        if (lvl && hs && !m_insv[i]) l_ev = 1'b1;
        if (we && a == 4'd6 && d[i]) e_ev = 1'b1;
        dlv = clk_en && m_pend[i] && m_en[i] && !m_insv[i];
        nx_int[i]  = dlv;
        nx_pend[i] = (e_ev || l_ev) ? 1'b1 : (dlv ? 1'b0 : m_pend[i]);
        nx_ovf[i]  = (e_ev && m_pend[i] && !dlv) ? 1'b1 :
                     ((we && a == 4'd5 && d[i]) ? 1'b0 : m_ovf[i]);
        nx_insv[i] = (dlv && lvl) ? 1'b1 :
                     ((we && a == 4'd4 && d[i]) ? 1'b0 : m_insv[i]);
      end
`ifdef IRQ_TIMER_EN
      if (ctrl_wr) begin
        m_ten = d[0]; m_tper = d[1];
        if (d[0]) m_tcnt = m_tload;
      end else if (m_ten && clk_en) begin
        if (m_tcnt == 0) begin
          if (m_tper) m_tcnt = m_tload; else m_ten = 1'b0;
        end else m_tcnt = m_tcnt - 1;
      end
      if (we && a == 4'd7) m_tload = d;
`endif
      if (we && a == 4'd0) m_en = d[N-1:0];
      if (we && a == 4'd1) m_mode = d[N-1:0];
      m_pend = nx_pend; m_insv = nx_insv; m_ovf = nx_ovf; m_int = nx_int;
      for (int k = SS; k >= 1; k--) hist[k] = hist[k-1];
      hist[0] = irq_in;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      vectors++;
      if (interrupts !== m_int) begin
        errors++;
        $display("FAIL interrupts @%0t: got 0x%04h, model 0x%04h", $time, interrupts, m_int);
      end
      if (m_rd_chk) begin
        vectors++;
        if (bus_if.bus_rdata !== m_rdata) begin
          errors++;
          $display("FAIL bus_rdata @%0t: got 0x%08h, model 0x%08h", $time, bus_if.bus_rdata, m_rdata);
        end
      end
    end
  end

  task automatic expect_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus_if.bus_we = 1'b1; bus_if.bus_addr = a; bus_if.bus_wdata = d;
    @(negedge clk);
    bus_if.bus_we = 1'b0;
  endtask

  task automatic rd(input string nm, input logic [3:0] a, input logic [31:0] exp);
    bus_if.bus_re = 1'b1; bus_if.bus_addr = a;
    @(negedge clk);
    bus_if.bus_re = 1'b0;
    expect_eq(nm, bus_if.bus_rdata, exp);
  endtask

  task automatic do_reset();
    irq_in = '0; clk_en = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int cnt;
    bit seen;
    rst = 1'b1; clk_en = 1'b1; irq_in = '0;
    bus_if.bus_we = 1'b0; bus_if.bus_re = 1'b0;
    bus_if.bus_addr = '0; bus_if.bus_wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_on = 1'b1;
    expect_eq("reset_interrupts", interrupts, '0);
    rd("reset_enable", REG_ENABLE, 0);

    // Edge mode on line 2: pulse 4 cycles after the raw rise
    wr(REG_ENABLE, 32'h0004);
    irq_in[2] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 3) expect_eq("edge_not_early", interrupts, '0);
      if (k == 4) expect_eq("edge_pulse", interrupts, 32'h0004);
      if (k == 5) begin
        expect_eq("edge_single", interrupts, '0);
        irq_in[2] = 1'b0;
      end
    end
    rd("edge_pending_clear", REG_PENDING, 0);

    // Level mode on line 4 with EOI
    do_reset();
    wr(REG_MODE, 32'h0010);
    wr(REG_ENABLE, 32'h0010);
    irq_in[4] = 1'b1;
    repeat (8) @(negedge clk);
    rd("level_inservice", REG_INSERVICE, 32'h0010);
    wr(REG_EOI, 32'h0010);
    @(negedge clk);
    expect_eq("level_eoi_repulse", interrupts, 32'h0010);
    irq_in[4] = 1'b0;
    repeat (6) @(negedge clk);
    rd("level_inservice_again", REG_INSERVICE, 32'h0010);

    // Masked software triggers, MODE write keeps PENDING
    do_reset();
    wr(REG_SWTRIG, 32'h8001);
    rd("sw_pending", REG_PENDING, 32'h8001);
    wr(REG_MODE, 32'h8000);
    rd("mode_keeps_pending", REG_PENDING, 32'h8001);
    wr(REG_MODE, 32'h0000);
    wr(REG_ENABLE, 32'hFFFF);
    @(negedge clk);
    expect_eq("sw_pulse", interrupts, 32'h8001);
    @(negedge clk);
    expect_eq("sw_single", interrupts, '0);
    rd("sw_pending_clear", REG_PENDING, 0);

    // clk_en low: accumulate with overflow, then deliver once
    do_reset();
    wr(REG_ENABLE, 32'h0008);
    clk_en = 1'b0;
    irq_in[3] = 1'b1; repeat (3) @(negedge clk);
    irq_in[3] = 1'b0; repeat (3) @(negedge clk);
    irq_in[3] = 1'b1; repeat (3) @(negedge clk);
    irq_in[3] = 1'b0; repeat (4) @(negedge clk);
    rd("gated_pending", REG_PENDING, 32'h0008);
    rd("gated_ovf", REG_OVF, 32'h0008);
    clk_en = 1'b1;
    @(negedge clk);
    expect_eq("ungated_pulse", interrupts, 32'h0008);
    @(negedge clk);
    expect_eq("ungated_single", interrupts, '0);
    wr(REG_OVF, 32'h0008);
    rd("ovf_cleared", REG_OVF, 0);

`ifdef IRQ_TIMER_EN
    do_reset();
    wr(REG_TIMER_LOAD, 32'd3);
    wr(REG_ENABLE, 32'h0001);
    wr(REG_TIMER_CTRL, 32'h3);
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clk);
      if (interrupts[0]) seen = 1'b1;
    end
    expect_eq("timer_first_pulse", {31'd0, seen}, 32'd1);
    cnt = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (interrupts[0]) cnt++;
    end
    expect_eq("timer_periodic_count", cnt, 4);
    wr(REG_TIMER_CTRL, 32'h1);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (interrupts[0]) cnt++;
    end
    expect_eq("timer_oneshot_count", cnt, 1);
    rd("timer_ctrl_cleared", REG_TIMER_CTRL, 0);
`else
    do_reset();
    wr(REG_TIMER_LOAD, 32'd5);
    rd("timer_load_absent", REG_TIMER_LOAD, 0);
    rd("timer_ctrl_absent", REG_TIMER_CTRL, 0);
    rd("unmapped_read", 4'hF, 0);
    wr(REG_ENABLE, 32'h0001);
    irq_in[0] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 4) expect_eq("line0_device_pulse", interrupts, 32'h0001);
    end
    irq_in[0] = 1'b0;
`endif

    // Reset while bits are pending
    do_reset();
    clk_en = 1'b0;
    wr(REG_ENABLE, 32'h00FF);
    wr(REG_SWTRIG, 32'h00FF);
    rd("pre_reset_pending", REG_PENDING, 32'h00FF);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clk_en = 1'b1;
    expect_eq("post_reset_interrupts", interrupts, '0);
    rd("post_reset_enable", REG_ENABLE, 0);
    rd("post_reset_pending", REG_PENDING, 0);
    rd("post_reset_ovf", REG_OVF, 0);
    repeat (4) @(negedge clk);
    expect_eq("post_reset_no_pulse", interrupts, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
